accum_sample_checker: RTL and testbench
=======================================

Name: accum_sample_checker

Overview:
- Sits directly downstream of the accumulator black-box wrapper and consumes its per-cycle 16-bit data output.
- Checks that each new sample equals the previous sample plus a fixed step, modulo 2^WIDTH.
- Tags every sample with an error flag and buffers the tagged samples in a small FIFO with a ready/valid output.
- Keeps saturating error and drop counters, and can halt on the first error for debug capture.

Parameters:
- WIDTH, 16, data width of the accumulator samples.
- STEP, 1, expected per-sample increment; all arithmetic is modulo 2^WIDTH.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- STOP_ON_ERR, 0, when 1 the first mismatch moves the block to HALT.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- io_en  input  1  sample enable: when high, io_in_data is consumed this cycle.
- io_in_data  input  WIDTH  accumulator value from the upstream wrapper.
- io_clear  input  1  synchronous clear pulse; flushes FIFO and counters, returns to IDLE.
- io_out_valid  output  1  FIFO head holds a sample.
- io_out_ready  input  1  downstream accepts the head sample.
- io_out_data  output  WIDTH  FIFO head data; 0 when empty.
- io_out_err  output  1  FIFO head error flag; 0 when empty.
- io_err_count  output  16  saturating mismatch count.
- io_drop_count  output  16  saturating count of samples lost to a full FIFO.
- io_state  output  2  current state: 0 IDLE, 1 RUN, 2 HALT.
- io_halted  output  1  high when state is HALT.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, FIFO empty, io_out_valid=0, io_out_data=0, io_out_err=0, both counters 0, prev register 0.
- Priority of controls: reset, then io_clear, then normal operation.
  - io_clear has the same effect as reset and acts in any state, including HALT.
- IDLE:
  - io_en=1: capture prev<=io_in_data and push {io_in_data, err=0} into the FIFO; no check on the first sample; next state RUN.
  - io_en=0: remain in IDLE.
- RUN:
  - io_en=1: err = (io_in_data != (prev+STEP) mod 2^WIDTH).
  - Push {io_in_data, err} and set prev<=io_in_data; prev updates even when the sample is an error or is dropped.
  - If err, io_err_count increments, saturating at 0xFFFF.
  - If err and STOP_ON_ERR=1, next state HALT; the erroneous sample is still pushed.
  - io_en=0: next state IDLE, so the next enabled sample re-primes without a check.
- HALT:
  - No pushes and no checks; prev and counters are frozen.
  - FIFO continues to drain normally.
  - Leaves only on reset or io_clear.
- FIFO:
  - Pop occurs when io_out_valid && io_out_ready.
  - A push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the sample is dropped and io_drop_count increments, saturating at 0xFFFF.
  - Simultaneous push and pop on an empty FIFO: no pop occurs (valid=0); the push lands.
  - io_out_valid = (occupancy != 0); io_out_data and io_out_err come combinationally from the head entry.
- Latency: a sample presented at edge N appears on io_out_data after edge N, provided the FIFO was empty (one cycle).
- Ordering: strict FIFO order; no reordering; pointers wrap modulo DEPTH.
- Counter timing: counters update on the same edge as the corresponding push or drop decision.

Test Plan:
- Reset, io_en=1, inputs 5,6,7,8, io_out_ready=1 -> outputs 5,6,7,8 each one cycle later, io_out_err=0 on all, io_err_count=0, io_state=1.
- Wrap: inputs 0xFFFE,0xFFFF,0x0000,0x0001 -> no errors, io_err_count=0.
- Discontinuity with STOP_ON_ERR=0: inputs 10,11,20,21 -> sample 20 has io_out_err=1, sample 21 has err=0, io_err_count=1.
- Backpressure, DEPTH=4, io_out_ready=0: inputs 1..6 -> io_drop_count=2; a later drain yields 1,2,3,4 in order.
- Full FIFO with simultaneous pop and push -> push accepted, io_drop_count unchanged.
- STOP_ON_ERR=1: inputs 3,4,9,10 -> after 9, io_halted=1, io_state=2, and 10 is not pushed; FIFO drains 3,4,9(err=1). A io_clear pulse then gives io_state=0 and both counters 0.
- Enable gap: inputs 5,6, then io_en=0 for one cycle, then 100,101 -> no errors, because 100 re-primes the check.

Source files
------------

// File: rtl/accum_sample_checker.sv
`default_nettype none
// ============================================================================
//  Module      : accum_sample_checker
//  Description : Checks that consecutive accumulator samples advance by a
//                fixed step (mod 2^WIDTH), tags each sample with an error
//                flag, and buffers tagged samples in a small ready/valid FIFO.
//                Saturating error and drop counters; optional halt on the
//                first mismatch for debug capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_sample_checker #(
    parameter int WIDTH       = 16,
    parameter int STEP        = 1,
    parameter int DEPTH       = 4,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic [WIDTH-1:0] io_in_data,
    input  logic             io_clear,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_data,
    output logic             io_out_err,
    output logic [15:0]      io_err_count,
    output logic [15:0]      io_drop_count,
    output logic [1:0]       io_state,
    output logic             io_halted
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] C_STEP  = WIDTH'(STEP);
    localparam logic [AW:0]    C_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    C_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0]  C_PONE  = AW'(1);
    localparam logic [15:0]    C_SAT   = 16'hFFFF;
    localparam logic [15:0]    C_CONE  = 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH:0]   r_mem [DEPTH];   // {err, data}
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [15:0]      r_err_count;
    logic [15:0]      r_drop_count;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             w_flush;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_active;
    logic [WIDTH-1:0] w_expect;
    logic             w_mismatch;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH:0]   w_head;

    // Reset and clear have identical effect; reset simply wins if both are set.
    assign w_flush    = reset | io_clear;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    // A pop needs a valid head, so push+pop on an empty FIFO is just a push.
    assign w_pop      = ~w_empty & io_out_ready;
    // Samples are only consumed in IDLE (priming) and RUN (checked).
    assign w_active   = io_en & ((r_state == ST_IDLE) | (r_state == ST_RUN));
    assign w_expect   = r_prev + C_STEP;
    assign w_mismatch = io_en & (r_state == ST_RUN) & (io_in_data != w_expect);
    // A full FIFO still takes the sample when the head leaves this cycle.
    assign w_push     = w_active & (~w_full | w_pop);
    assign w_drop     = w_active & w_full & ~w_pop;
    assign w_head     = r_mem[r_rd_ptr];

    // Control state machine and previous-sample register
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_state <= ST_IDLE;
            r_prev  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_en) begin
                        r_prev  <= io_in_data;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (io_en) begin
                        // prev tracks the raw input even for bad or dropped samples
                        r_prev <= io_in_data;
                        if (w_mismatch && (STOP_ON_ERR != 0)) begin
                            r_state <= ST_HALT;
                        end
                    end else begin
                        // An enable gap forces the next sample to re-prime
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by occupancy
    always_ff @(posedge clock) begin
        if (!w_flush && w_push) begin
            r_mem[r_wr_ptr] <= {w_mismatch, io_in_data};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating mismatch and drop counters
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_mismatch && (r_err_count != C_SAT)) begin
                r_err_count <= r_err_count + C_CONE;
            end
            if (w_drop && (r_drop_count != C_SAT)) begin
                r_drop_count <= r_drop_count + C_CONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_out_valid  = ~w_empty;
    assign io_out_data   = w_empty ? '0 : w_head[WIDTH-1:0];
    assign io_out_err    = ~w_empty & w_head[WIDTH];
    assign io_err_count  = r_err_count;
    assign io_drop_count = r_drop_count;
    assign io_state      = r_state;
    assign io_halted     = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_accum_sample_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_sample_checker
//  Description : Self-checking bench for accum_sample_checker. Two instances
//                (STOP_ON_ERR=0 and 1) share stimulus; a queue-based
//                reference model predicts every output after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_sample_checker;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        en;
    logic [15:0] in_data;
    logic        clear;
    logic        ready;

    logic        valid   [2];
    logic [15:0] odata   [2];
    logic        oerr    [2];
    logic [15:0] errc    [2];
    logic [15:0] dropc   [2];
    logic [1:0]  state   [2];
    logic        halted  [2];

    int n_checks;
    int n_errors;

    // Reference model state, one slot per instance
    logic [16:0] mq [2][$];     // {err, data}
    int          m_state [2];   // 0 idle, 1 run, 2 halt
    logic [15:0] m_prev  [2];
    int          m_errc  [2];
    int          m_dropc [2];

    accum_sample_checker #(.WIDTH(16), .STEP(1), .DEPTH(DEPTH), .STOP_ON_ERR(0)) u_dut0 (
        .clock(clock), .reset(reset), .io_en(en), .io_in_data(in_data),
        .io_clear(clear), .io_out_valid(valid[0]), .io_out_ready(ready),
        .io_out_data(odata[0]), .io_out_err(oerr[0]), .io_err_count(errc[0]),
        .io_drop_count(dropc[0]), .io_state(state[0]), .io_halted(halted[0])
    );

    accum_sample_checker #(.WIDTH(16), .STEP(1), .DEPTH(DEPTH), .STOP_ON_ERR(1)) u_dut1 (
        .clock(clock), .reset(reset), .io_en(en), .io_in_data(in_data),
        .io_clear(clear), .io_out_valid(valid[1]), .io_out_ready(ready),
        .io_out_data(odata[1]), .io_out_err(oerr[1]), .io_err_count(errc[1]),
        .io_drop_count(dropc[1]), .io_state(state[1]), .io_halted(halted[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one clock, using the inputs about to be sampled
    task automatic model_step(input int k);
        bit          pop;
        bit          push;
        bit          err;
        logic [15:0] expv;
        if (reset || clear) begin
            mq[k].delete();
            m_state[k] = 0;
            m_prev[k]  = 16'd0;
            m_errc[k]  = 0;
            m_dropc[k] = 0;
            return;
        end
        pop  = (mq[k].size() != 0) && ready;
        push = 1'b0;
        err  = 1'b0;
        if (en && m_state[k] == 0) begin
            push       = 1'b1;
            m_prev[k]  = in_data;
            m_state[k] = 1;
        end else if (m_state[k] == 1) begin
            if (en) begin
                expv = 16'((32'(m_prev[k]) + 1) % 65536);
                err  = (in_data != expv);
                push = 1'b1;
                m_prev[k] = in_data;
                if (err) begin
                    if (m_errc[k] < 65535) m_errc[k]++;
                    if (k == 1) m_state[k] = 2;
                end
            end else begin
                m_state[k] = 0;
            end
        end
        if (push) begin
            if (mq[k].size() < DEPTH || pop) begin
                if (pop) void'(mq[k].pop_front());
                mq[k].push_back({err, in_data});
                pop = 1'b0;
            end else begin
                if (m_dropc[k] < 65535) m_dropc[k]++;
            end
        end
        if (pop) void'(mq[k].pop_front());
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit          e_valid;
            logic [16:0] head;
            e_valid = (mq[k].size() != 0);
            head    = e_valid ? mq[k][0] : 17'd0;
            check($sformatf("valid%0d", k),  32'(valid[k]),  32'(e_valid));
            check($sformatf("data%0d", k),   32'(odata[k]),  32'(head[15:0]));
            check($sformatf("err%0d", k),    32'(oerr[k]),   32'(head[16]));
            check($sformatf("errcnt%0d", k), 32'(errc[k]),   32'(m_errc[k]));
            check($sformatf("dropcnt%0d", k),32'(dropc[k]),  32'(m_dropc[k]));
            check($sformatf("state%0d", k),  32'(state[k]),  32'(m_state[k]));
            check($sformatf("halted%0d", k), 32'(halted[k]), 32'(m_state[k] == 2));
        end
    endtask

    // One clock: drive inputs, update model, then compare after the edge
    task automatic cyc(input logic e, input logic [15:0] d, input logic r, input logic c);
        en = e; in_data = d; ready = r; clear = c;
        model_step(0);
        model_step(1);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] seq [4];
        logic [15:0] nxt;
        n_checks = 0;
        n_errors = 0;
        en = 0; in_data = 0; ready = 0; clear = 0; reset = 1;

        // Reset state
        cyc(0, 16'd0, 0, 0);
        cyc(0, 16'd0, 0, 0);
        reset = 0;
        check("rst_valid", 32'(valid[0]), 0);
        check("rst_state", 32'(state[0]), 0);

        // Basic streaming with one-cycle latency
        cyc(1, 16'd5, 1, 0);
        check("lat_first", 32'(odata[0]), 5);
        cyc(1, 16'd6, 1, 0);
        cyc(1, 16'd7, 1, 0);
        cyc(1, 16'd8, 1, 0);
        check("basic_last", 32'(odata[0]), 8);
        check("basic_state", 32'(state[0]), 1);
        check("basic_errc", 32'(errc[0]), 0);

        // Modular wrap
        cyc(0, 16'd0, 1, 1);
        cyc(1, 16'hFFFE, 1, 0);
        cyc(1, 16'hFFFF, 1, 0);
        cyc(1, 16'h0000, 1, 0);
        check("wrap_err", 32'(oerr[0]), 0);
        cyc(1, 16'h0001, 1, 0);
        check("wrap_errc", 32'(errc[0]), 0);

        // Discontinuity, no stop
        cyc(0, 16'd0, 1, 1);
        cyc(1, 16'd10, 1, 0);
        cyc(1, 16'd11, 1, 0);
        cyc(1, 16'd20, 1, 0);
        check("disc_flag20", 32'(oerr[0]), 1);
        cyc(1, 16'd21, 1, 0);
        check("disc_flag21", 32'(oerr[0]), 0);
        check("disc_errc", 32'(errc[0]), 1);

        // Backpressure: 1..6 into a 4-deep FIFO drops 2
        cyc(0, 16'd0, 1, 1);
        for (int i = 1; i <= 6; i++) cyc(1, 16'(i), 0, 0);
        check("bp_drop", 32'(dropc[0]), 2);
        check("bp_head", 32'(odata[0]), 1);
        // Full FIFO with simultaneous pop and push: accepted, no drop
        cyc(1, 16'd7, 1, 0);
        check("fullpp_drop", 32'(dropc[0]), 2);
        seq[0] = 16'd2; seq[1] = 16'd3; seq[2] = 16'd4; seq[3] = 16'd7;
        for (int i = 0; i < 4; i++) begin
            check("bp_order", 32'(odata[0]), 32'(seq[i]));
            cyc(0, 16'd0, 1, 0);
        end
        check("bp_empty", 32'(valid[0]), 0);

        // Stop on error (instance 1)
        cyc(0, 16'd0, 0, 1);
        cyc(1, 16'd3, 0, 0);
        cyc(1, 16'd4, 0, 0);
        cyc(1, 16'd9, 0, 0);
        check("halt_flag", 32'(halted[1]), 1);
        check("halt_state", 32'(state[1]), 2);
        cyc(1, 16'd10, 0, 0);
        seq[0] = 16'd3; seq[1] = 16'd4; seq[2] = 16'd9;
        for (int i = 0; i < 3; i++) begin
            check("halt_order", 32'(odata[1]), 32'(seq[i]));
            check("halt_errbit", 32'(oerr[1]), 32'(i == 2));
            cyc(0, 16'd0, 1, 0);
        end
        check("halt_empty", 32'(valid[1]), 0);
        cyc(0, 16'd0, 0, 1);
        check("clr_state", 32'(state[1]), 0);
        check("clr_errc", 32'(errc[1]), 0);
        check("clr_drop", 32'(dropc[0]), 0);

        // Enable gap re-primes the check
        cyc(1, 16'd5, 1, 0);
        cyc(1, 16'd6, 1, 0);
        cyc(0, 16'd0, 1, 0);
        cyc(1, 16'd100, 1, 0);
        cyc(1, 16'd101, 1, 0);
        check("gap_errc0", 32'(errc[0]), 0);
        check("gap_errc1", 32'(errc[1]), 0);

        // Randomized traffic against the model
        nxt = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            logic        e;
            logic        r;
            logic        c;
            logic [15:0] d;
            e = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 9) < 5);
            c = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 9) == 0) ? 16'($urandom) : nxt;
            if (e) nxt = d + 16'd1;
            reset = ($urandom_range(0, 499) == 0);
            cyc(e, d, r, c);
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
